// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program counter with return-address stack.
// Op encodings and default address width.
package pc_stack_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_LOAD   = 3'b010,
    OP_BRANCH = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101
  } op_e;

endpackage

// File: rtl/pc_stack_if.sv
// Decoder/fetch-side bundle for pc_stack.
// master drives control; slave is the PC itself.
interface pc_stack_if
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 8
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             clear;
  logic             stall;
  logic [2:0]       op;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, stall, op, in,
    input  out, top, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  clear, stall, op, in,
    output out, top, count, empty, full,
    output overflow, underflow
  );

endinterface

// File: rtl/pc_stack_ret_stack.sv
// Circular return-address LIFO; pushing while full drops the oldest.
// Pops on an empty stack are refused and reported as blocked.
module pc_stack_ret_stack
  import pc_stack_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             blocked
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW-1:0]    wp_inc;
  logic [CW-1:0]    cnt;

  assign wp_inc = (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
  assign rp     = (wp == '0) ? PW'(DEPTH - 1) : wp - 1'b1;

  assign count   = cnt;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign top     = empty ? '0 : mem[rp];
  assign blocked = pop && empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp] <= data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      wp <= wp_inc;
      if (!full) begin
        cnt <= cnt + 1'b1;
      end
    end else if (pop && !empty) begin
      wp  <= rp;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with branch, call/return stack, stall and clear.
// PC register, next-PC mux and sticky stack error flags.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] STEP         = WIDTH'(1)
) (
  input logic        clock,
  input logic        reset,
  pc_stack_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] stk_top;
  logic [CW-1:0]    stk_count;
  logic             stk_empty;
  logic             stk_full;
  logic             blocked;
  logic             go;
  logic             push;
  logic             pop;
  logic             ovf;
  logic             unf;

  assign go       = !bus.clear && !bus.stall;
  assign push     = go && (bus.op == OP_CALL);
  assign pop      = go && (bus.op == OP_RET);
  assign ret_addr = pc + STEP;

  pc_stack_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clock   (clock),
    .reset   (reset),
    .clear   (bus.clear),
    .push    (push),
    .pop     (pop),
    .data    (ret_addr),
    .top     (stk_top),
    .count   (stk_count),
    .empty   (stk_empty),
    .full    (stk_full),
    .blocked (blocked)
  );

  always_comb begin
    pc_nxt = pc;
    unique case (bus.op)
      OP_INC:    pc_nxt = pc + STEP;
      OP_LOAD:   pc_nxt = bus.in;
      OP_BRANCH: pc_nxt = pc + bus.in;
      OP_CALL:   pc_nxt = bus.in;
      OP_RET:    pc_nxt = stk_empty ? pc : stk_top;
      default:   pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_VECTOR;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (bus.clear) begin
      pc  <= RESET_VECTOR;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!bus.stall) begin
      pc <= pc_nxt;
      if (push && stk_full) begin
        ovf <= 1'b1;
      end
      if (blocked) begin
        unf <= 1'b1;
      end
    end
  end

  assign bus.out       = pc;
  assign bus.top       = stk_top;
  assign bus.count     = stk_count;
  assign bus.empty     = stk_empty;
  assign bus.full      = stk_full;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;

endmodule

// File: tb/tb_pc_stack.sv
// Directed-vector bench for pc_stack (WIDTH=16, DEPTH=4).
// Table of per-cycle ops with hand-computed results plus reset sequence.
module tb_pc_stack;

  localparam int W = 16;
  localparam int D = 4;

  typedef struct {
    string       name;
    logic        clr;
    logic        stl;
    logic [2:0]  op;
    logic [15:0] in;
    logic [15:0] out;
    logic [15:0] top;
    logic [2:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic clock;
  logic reset;
  int   nvec;
  int   nerr;
  vec_t vq[$];

  pc_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pc_stack #(
    .WIDTH        (W),
    .DEPTH        (D),
    .RESET_VECTOR (16'h0000),
    .STEP         (16'h0001)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(
    string nm, logic c, logic s, logic [2:0] o, logic [15:0] i,
    logic [15:0] eo, logic [15:0] et, logic [2:0] ec,
    logic ee, logic ef, logic eov, logic eun
  );
    vec_t v;
    v.name = nm; v.clr = c; v.stl = s; v.op = o; v.in = i;
    v.out = eo; v.top = et; v.cnt = ec;
    v.emp = ee; v.ful = ef; v.ovf = eov; v.unf = eun;
    return v;
  endfunction

  task automatic check(
    string nm, logic [15:0] eo, logic [15:0] et, logic [2:0] ec,
    logic ee, logic ef, logic eov, logic eun
  );
    logic [38:0] act;
    logic [38:0] exp;
    act = {bus.out, bus.top, bus.count, bus.empty, bus.full,
           bus.overflow, bus.underflow};
    exp = {eo, et, ec, ee, ef, eov, eun};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: out=%h top=%h cnt=%0d e/f/o/u=%b%b%b%b, want out=%h top=%h cnt=%0d e/f/o/u=%b%b%b%b",
        nm, bus.out, bus.top, bus.count, bus.empty, bus.full,
        bus.overflow, bus.underflow, eo, et, ec, ee, ef, eov, eun);
    end
  endtask

  task automatic drive(logic c, logic s, logic [2:0] o, logic [15:0] i);
    bus.clear = c;
    bus.stall = s;
    bus.op    = o;
    bus.in    = i;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 16'h0000);

    vq.push_back(mk("load15", 0,0,3'b010,16'h000F, 16'h000F,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("inc1",   0,0,3'b001,16'h0000, 16'h0010,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("inc2",   0,0,3'b001,16'h0000, 16'h0011,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("inc3",   0,0,3'b001,16'h0000, 16'h0012,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("hold",   0,0,3'b000,16'h1234, 16'h0012,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("stall1", 0,1,3'b001,16'h0000, 16'h0012,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("stall2", 0,1,3'b001,16'h0000, 16'h0012,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("rsv111", 0,0,3'b111,16'h5555, 16'h0012,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("rsv110", 0,0,3'b110,16'h5555, 16'h0012,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("ldfffe", 0,0,3'b010,16'hFFFE, 16'hFFFE,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("br+3",   0,0,3'b011,16'h0003, 16'h0001,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("br-1",   0,0,3'b011,16'hFFFF, 16'h0000,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("ld10",   0,0,3'b010,16'h0010, 16'h0010,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("call1",  0,0,3'b100,16'h0100, 16'h0100,16'h0011,3'd1, 0,0,0,0));
    vq.push_back(mk("call2",  0,0,3'b100,16'h0200, 16'h0200,16'h0101,3'd2, 0,0,0,0));
    vq.push_back(mk("ret1",   0,0,3'b101,16'h0000, 16'h0101,16'h0011,3'd1, 0,0,0,0));
    vq.push_back(mk("ret2",   0,0,3'b101,16'h0000, 16'h0011,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("ld0",    0,0,3'b010,16'h0000, 16'h0000,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("c10",    0,0,3'b100,16'h0010, 16'h0010,16'h0001,3'd1, 0,0,0,0));
    vq.push_back(mk("c20",    0,0,3'b100,16'h0020, 16'h0020,16'h0011,3'd2, 0,0,0,0));
    vq.push_back(mk("c30",    0,0,3'b100,16'h0030, 16'h0030,16'h0021,3'd3, 0,0,0,0));
    vq.push_back(mk("c40",    0,0,3'b100,16'h0040, 16'h0040,16'h0031,3'd4, 0,1,0,0));
    vq.push_back(mk("c50ovf", 0,0,3'b100,16'h0050, 16'h0050,16'h0041,3'd4, 0,1,1,0));
    vq.push_back(mk("r41",    0,0,3'b101,16'h0000, 16'h0041,16'h0031,3'd3, 0,0,1,0));
    vq.push_back(mk("r31",    0,0,3'b101,16'h0000, 16'h0031,16'h0021,3'd2, 0,0,1,0));
    vq.push_back(mk("r21",    0,0,3'b101,16'h0000, 16'h0021,16'h0011,3'd1, 0,0,1,0));
    vq.push_back(mk("r11",    0,0,3'b101,16'h0000, 16'h0011,16'h0000,3'd0, 1,0,1,0));
    vq.push_back(mk("runf",   0,0,3'b101,16'h0000, 16'h0011,16'h0000,3'd0, 1,0,1,1));
    vq.push_back(mk("stlret", 0,1,3'b101,16'h0000, 16'h0011,16'h0000,3'd0, 1,0,1,1));
    vq.push_back(mk("c30b",   0,0,3'b100,16'h0030, 16'h0030,16'h0012,3'd1, 0,0,1,1));
    vq.push_back(mk("c40b",   0,0,3'b100,16'h0040, 16'h0040,16'h0031,3'd2, 0,0,1,1));
    vq.push_back(mk("clear",  1,1,3'b100,16'h0099, 16'h0000,16'h0000,3'd0, 1,0,0,0));
    vq.push_back(mk("c08",    0,0,3'b100,16'h0008, 16'h0008,16'h0001,3'd1, 0,0,0,0));
    vq.push_back(mk("r01",    0,0,3'b101,16'h0000, 16'h0001,16'h0000,3'd0, 1,0,0,0));

    // Asynchronous reset with no clock edge, then mid-cycle assertion.
    #2;
    check("por", 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b100, 16'h0100);
    step();
    check("call100", 16'h0100, 16'h0001, 3'd1, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 3'b001, 16'h0000);
    #2;
    reset = 1'b0;
    #1;
    check("asyncrst", 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0);
    #2;
    reset = 1'b1;
    step();
    check("inc_after", 16'h0001, 16'h0000, 3'd0, 1, 0, 0, 0);

    foreach (vq[k]) begin
      drive(vq[k].clr, vq[k].stl, vq[k].op, vq[k].in);
      step();
      check(vq[k].name, vq[k].out, vq[k].top, vq[k].cnt,
            vq[k].emp, vq[k].ful, vq[k].ovf, vq[k].unf);
    end

    // Flags set, then async reset mid-cycle must clear them.
    drive(1'b0, 1'b0, 3'b101, 16'h0000);
    step();
    check("unf2", 16'h0001, 16'h0000, 3'd0, 1, 0, 0, 1);
    #3;
    reset = 1'b0;
    #1;
    check("rst_flags", 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 16'h0000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter, successor to the Hack PC.
- Adds relative branch, call/return via an internal return-address stack, pipeline stall, and a configurable reset vector.
- Sits between the instruction decoder (drives `op`/`in`) and instruction memory (consumes `out`).
- Output is registered; one operation per clock.

Parameters:
- WIDTH, 16, address width in bits; all arithmetic is modulo 2^WIDTH.
- DEPTH, 8, return-stack entries; must be ≥2.
- RESET_VECTOR, 0, value loaded into `out` on reset or clear.
- STEP, 1, increment amount for INC and for the CALL return address.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- clear, input, 1, synchronous soft restart, active-high.
- stall, input, 1, freezes all state when high.
- op, input, 3, operation select (encodings below).
- in, input, WIDTH, jump target or signed branch offset.
- out, output, WIDTH, current program counter.
- top, output, WIDTH, return address at top of stack; 0 when empty.
- count, output, $clog2(DEPTH+1), number of valid stack entries.
- empty, output, 1, high when count==0.
- full, output, 1, high when count==DEPTH.
- overflow, output, 1, sticky; set by CALL while full.
- underflow, output, 1, sticky; set by RET while empty.

Behaviour:
- reset=0, asynchronous, no clock needed:
  - out=RESET_VECTOR, count=0, stack pointer=0.
  - overflow=0, underflow=0.
  - Stack storage is not cleared.
- Priority at each rising edge: reset > clear > stall > op.
- clear=1: same register effect as reset, but synchronous. `op` is ignored, so no push or pop occurs.
- stall=1, clear=0: all registers hold and `op` is ignored.
- op encodings:
  - 000 HOLD: out holds.
  - 001 INC: out <= out+STEP.
  - 010 LOAD: out <= in.
  - 011 BRANCH: out <= out+in; `in` is two's complement; wraps modulo 2^WIDTH.
  - 100 CALL: push out+STEP (wrapped); out <= in; count+1.
  - 101 RET: out <= popped entry; count-1.
  - 110, 111: reserved; behave as HOLD. No flag is set.
- Latency: the result of `op` is visible on `out` one edge later. `top`, `count`, `empty` and `full` are derived combinationally from registered state.
- CALL while full:
  - Storage is circular, so the push overwrites the oldest entry.
  - count stays DEPTH; overflow is set (sticky).
  - `out` is still loaded with `in`.
- RET while empty:
  - out holds; count stays 0; underflow is set (sticky).
  - Stack pointer is unchanged.
- Sticky flags clear only on reset or clear.
- Stack pointer wrap-around: the write index advances modulo DEPTH. The read index is always write index−1 (mod DEPTH).
- Back-to-back CALL→RET on consecutive cycles returns the just-pushed address. No bubble is allowed.
- reset asserted mid-operation: the operation in progress is abandoned; outputs take reset values immediately. The first op takes effect on the first rising edge after reset deasserts.

Decomposition:
- Shared include `pc_defs.vh`:
  - Op encoding constants: OP_HOLD, OP_INC, OP_LOAD, OP_BRANCH, OP_CALL, OP_RET.
  - The default WIDTH.
- One sub-module: `ret_stack`.
  - Circular LIFO of DEPTH×WIDTH with push, pop, top, count, full and empty.
  - Drop-oldest on push while full.
  - Reports blocked pops to the parent.
- The parent holds the PC register, next-PC mux, adder and sticky flags.

Test Plan (WIDTH=16, DEPTH=4, RESET_VECTOR=0, STEP=1):
1. Async reset:
   - Run CALL in=0x0100 so out=0x0100, count=1.
   - Drive reset=0 between clock edges → out=0, count=0, flags=0 with no clock edge.
   - Release reset → the next INC gives out=1.
2. Basic ops:
   - LOAD in=15 → out=15.
   - INC ×3 → 18.
   - HOLD → 18.
   - stall=1 with INC for 2 cycles → 18.
   - op=111 → 18.
3. Branch wrap:
   - From out=0xFFFE, BRANCH in=0x0003 → out=0x0001.
   - BRANCH in=0xFFFF → out=0x0000.
4. Call/return:
   - From out=0x0010, CALL in=0x0100 → out=0x0100, top=0x0011, count=1.
   - CALL in=0x0200 → top=0x0101, count=2.
   - RET → out=0x0101, count=1.
   - RET → out=0x0011, count=0, empty=1.
5. Overflow and underflow:
   - From out=0, five CALLs with in=0x10, 0x20, 0x30, 0x40, 0x50 → count=4, full=1, overflow=1.
   - Four RETs return 0x41, 0x31, 0x21, 0x11 in that order.
   - Fifth RET → out holds at 0x11, underflow=1, count=0.
6. Clear priority:
   - With count=2, assert clear=1 with op=CALL and stall=1 → out=0, count=0, flags cleared, no push.
   - The next CALL in=0x0008 → out=0x0008, top=0x0001.
